// File: rtl/mem_resp_pkg.sv
// Shared encodings, FSM state type and byte-enable helper for the memory responder.
package mem_resp_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Lane enables for a store; a half uses lanes {1,0} or {3,2} chosen by a[1].
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_BYTE: be = 4'b0001 << a;
            SIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU <-> memory responder request/response bundle.
interface mem_responder_if;
    import mem_resp_pkg::*;

    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, size, addr, wdata,
        input  busy, ack, err, rdata
    );

    modport slave (
        input  req, we, size, addr, wdata,
        output busy, ack, err, rdata
    );

endinterface

// File: rtl/mem_resp_ram.sv
// Byte-lane storage: one array per lane, synchronous write, combinational read so a
// load result can be registered on the same edge that commits a store.
module mem_resp_ram #(
    parameter int DEPTH_WORDS = 64,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (we_i && be_i[gi]) begin
                    lane_mem[idx_i] <= wdata_i[gi*8 +: 8];
                end
            end

            assign rdata_o[gi*8 +: 8] = lane_mem[idx_i];
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder with alignment/range checking.
// Define MEM_RESP_SUBWORD_EN to enable byte/half accesses; otherwise every access is a word.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_responder_if.slave bus
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           we_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic           err_cap_q;
    logic           err_q;
    logic [31:0]    rdata_q;

    logic           live_err;
    logic           is_idle;
    logic           capture;
    logic           enter_resp;
    logic           acc_we;
    logic           acc_err;
    logic [AW+1:0]  acc_addr;
    logic [31:0]    acc_wdata;
    logic [3:0]     ram_be;
    logic           ram_we;
    logic [31:0]    ram_rdata;
    logic [31:0]    ld_shift;
    logic [31:0]    ld_data;

`ifdef MEM_RESP_SUBWORD_EN
    logic [1:0]     size_q;
    logic [1:0]     acc_size;
`endif

    assign is_idle = (state_q == ST_IDLE);
    assign capture = is_idle && bus.req;

    // Error classification of the live request; only consumed at capture.
    always_comb begin
        logic misalign;
        logic reserved;
        logic out_of_range;
        misalign = 1'b0;
        reserved = 1'b0;
`ifdef MEM_RESP_SUBWORD_EN
        case (bus.size)
            SIZE_HALF: misalign = bus.addr[0];
            SIZE_WORD: misalign = (bus.addr[1:0] != 2'b00);
            default:   misalign = 1'b0;
        endcase
        reserved = (bus.size == SIZE_RSVD);
`else
        misalign = (bus.addr[1:0] != 2'b00);
`endif
        out_of_range = (bus.addr[31:2] >= 30'(DEPTH_WORDS));
        live_err = misalign | reserved | out_of_range;
    end

    // FSM next state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

    // With zero wait states the access completes on its capture edge, so take it live.
    assign acc_we    = is_idle ? bus.we               : we_q;
    assign acc_addr  = is_idle ? bus.addr[AW+1:0]     : addr_q;
    assign acc_wdata = is_idle ? bus.wdata            : wdata_q;
    assign acc_err   = is_idle ? live_err             : err_cap_q;

`ifdef MEM_RESP_SUBWORD_EN
    assign acc_size = is_idle ? bus.size : size_q;
    assign ram_be   = byte_en(acc_size, acc_addr[1:0]);
`else
    assign ram_be   = 4'b1111;
`endif

    assign ram_we = enter_resp && acc_we && !acc_err;

    mem_resp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .idx_i   (acc_addr[AW+1:2]),
        .wdata_i (acc_wdata << {acc_addr[1:0], 3'b000}),
        .rdata_o (ram_rdata)
    );

    assign ld_shift = ram_rdata >> {acc_addr[1:0], 3'b000};

    always_comb begin
        ld_data = ld_shift;
`ifdef MEM_RESP_SUBWORD_EN
        case (acc_size)
            SIZE_BYTE: ld_data = {24'd0, ld_shift[7:0]};
            SIZE_HALF: ld_data = {16'd0, ld_shift[15:0]};
            default:   ld_data = ld_shift;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            err_cap_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
`ifdef MEM_RESP_SUBWORD_EN
            size_q    <= SIZE_WORD;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                we_q      <= bus.we;
                addr_q    <= bus.addr[AW+1:0];
                wdata_q   <= bus.wdata;
                err_cap_q <= live_err;
`ifdef MEM_RESP_SUBWORD_EN
                size_q    <= bus.size;
`endif
            end
            // Response registers only change when a new response is produced.
            if (enter_resp) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || acc_we) ? 32'd0 : ld_data;
            end
        end
    end

    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.ack   = (state_q == ST_RESP);
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

endmodule
